mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates the single shared data/instruction memory port between two requesters: the CPU datapath (fetch and load/store) and the debug/program loader.
- Latches the winning request, holds the memory address, write-enable and write-data lines stable for the memory's fixed latency, returns the read data, and pulses a one-cycle acknowledge to the winner.
- Sits between the requesters and the memory instance. The CPU control unit stalls on `cpu_ack`.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, memory cycles per access (≥1); read data is valid in the last access cycle
- MAX_WAIT, 8, cycles the loader may wait while the CPU wins before the loader is forced priority

Ports:
- clock  in  1  system clock, rising edge
- reset_l  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request (level)
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle pulse, CPU access complete
- ldr_req  in  1  loader access request (level)
- ldr_we  in  1  loader write / read
- ldr_addr  in  ADDR_W  loader address
- ldr_wdata  in  DATA_W  loader write data
- ldr_ack  out  1  one-cycle pulse, loader access complete
- rdata  out  DATA_W  read data of the last completed access
- mem_addr  out  ADDR_W  to memory Address
- mem_wr  out  1  to memory Wr
- mem_din  out  DATA_W  to memory Datain
- mem_dout  in  DATA_W  from memory Dataout
- busy  out  1  high in every state other than IDLE

Behaviour:
- Reset (async, reset_l=0):
  - State = IDLE.
  - All outputs are 0: rdata, mem_addr, mem_din, mem_wr, both acks, busy.
  - lat_cnt = 0, wait_cnt = 0, owner = CPU.
  - Reset mid-access aborts the access with no ack; mem_wr drops immediately.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - Winner selection:
    - If ldr_req and wait_cnt==MAX_WAIT, the loader wins.
    - Otherwise, if cpu_req, the CPU wins.
    - Otherwise, if ldr_req, the loader wins.
    - With no request, stay in IDLE.
  - On a grant, at the clock edge: latch owner, we, addr and wdata into internal registers; lat_cnt=0; go to ACCESS.
- ACCESS:
  - mem_addr and mem_din come from the latched registers; mem_wr = latched we, held for all MEM_LAT cycles.
  - Requester inputs changing during ACCESS have no effect.
  - lat_cnt increments each cycle.
  - When lat_cnt==MEM_LAT-1: if the access is a read, capture mem_dout into rdata at that edge; go to DONE.
  - rdata is unchanged on writes.
- DONE:
  - One cycle; ack pulses for the owner only; mem_wr=0; go to IDLE.
- Latency: request sampled in IDLE at edge T → ack high during cycle T+MEM_LAT+1.
  - Back-to-back throughput: one access per MEM_LAT+2 cycles.
- Requester rule: deassert req in the ack cycle, or present a new request.
  - A req still high when IDLE is re-entered is treated as a new access.
- wait_cnt (loader starvation counter):
  - Increments, saturating at MAX_WAIT, on each IDLE grant to the CPU while ldr_req is high.
  - Clears on a loader grant, or when ldr_req is low in IDLE.
- Simultaneous requests: the CPU wins unless wait_cnt==MAX_WAIT.
- Address/data are passed through unmodified; no width arithmetic.
- Outputs are registered except mem_wr and the acks, which are decoded from state and owner.

Test Plan:
- Reset then idle: reset_l=0 mid-sim → all outputs 0, busy=0. With no requests for 10 cycles, mem_wr stays 0.
- CPU read, MEM_LAT=2: mem holds 0xDEADBEEF at 0x40; cpu_req=1, cpu_we=0, cpu_addr=0x40 sampled at edge T → mem_addr=0x40 for 2 cycles; cpu_ack=1 in cycle T+3; rdata=0xDEADBEEF; ldr_ack stays 0.
- Loader write: ldr_we=1, ldr_addr=0x10, ldr_wdata=0x12345678 → mem_wr=1 for exactly 2 cycles with mem_din=0x12345678; ldr_ack pulses once; rdata unchanged.
- Simultaneous requests: both req high at the same edge → CPU served first. The loader is served in the following IDLE once cpu_req drops; 2 acks total, CPU ack first.
- Starvation, MAX_WAIT=8: cpu_req held high continuously with ldr_req high → 8 CPU grants, then the loader's grant on the 9th arbitration. wait_cnt returns to 0, and the CPU is granted next.
- Abort: reset_l pulsed low during ACCESS of a CPU write → mem_wr=0 immediately, no cpu_ack, state IDLE, and a fresh request after release completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter
// Shares one memory port between the CPU datapath and the debug/program loader.
// A request is sampled only in IDLE; the winner's address, write enable and
// write data are latched and held on the memory port for MEM_LAT cycles. Read
// data is captured in the last access cycle, then a one-cycle acknowledge goes
// to the winner. The loader is forced to win after MAX_WAIT consecutive CPU
// grants taken while it was waiting.
//
// Ports:
//   clock, reset_l             clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata      CPU request, level sensitive
//   cpu_ack                    one-cycle pulse, CPU access complete
//   ldr_req/we/addr/wdata      loader request, level sensitive
//   ldr_ack                    one-cycle pulse, loader access complete
//   rdata                      read data of the last completed read
//   mem_addr/mem_wr/mem_din    to the memory
//   mem_dout                   from the memory
//   busy                       high whenever the arbiter is not IDLE
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic              clock,
  input  logic              reset_l,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  localparam int LAT_W  = $clog2(MEM_LAT + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_reg, state_next;
  logic                owner_reg;          // 0 = CPU, 1 = loader
  logic                we_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   rdata_reg;
  logic [LAT_W-1:0]    lat_cnt_reg;
  logic [WAIT_W-1:0]   wait_cnt_reg;
  logic                busy_reg;

  logic                grant_cpu, grant_ldr;
  logic                lat_done;
  logic                ldr_starved;

  assign lat_done    = (lat_cnt_reg == LAT_W'(MEM_LAT - 1));
  assign ldr_starved = (wait_cnt_reg == WAIT_W'(MAX_WAIT));

  // Arbitration is only meaningful in IDLE; grants are forced low elsewhere so
  // requester activity during an access cannot disturb the latched request.
  always_comb begin
    grant_cpu = 1'b0;
    grant_ldr = 1'b0;
    if (state_reg == IDLE) begin
      if (ldr_req && ldr_starved) begin
        grant_ldr = 1'b1;
      end else if (cpu_req) begin
        grant_cpu = 1'b1;
      end else if (ldr_req) begin
        grant_ldr = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_cpu || grant_ldr) state_next = ACCESS;
      ACCESS:  if (lat_done) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state_reg    <= IDLE;
      owner_reg    <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      lat_cnt_reg  <= '0;
      wait_cnt_reg <= '0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != IDLE);

      if (grant_cpu || grant_ldr) begin
        owner_reg   <= grant_ldr;
        we_reg      <= grant_ldr ? ldr_we    : cpu_we;
        addr_reg    <= grant_ldr ? ldr_addr  : cpu_addr;
        wdata_reg   <= grant_ldr ? ldr_wdata : cpu_wdata;
        lat_cnt_reg <= '0;
      end

      if (state_reg == ACCESS) begin
        lat_cnt_reg <= lat_cnt_reg + LAT_W'(1);
        if (lat_done && !we_reg) begin
          rdata_reg <= mem_dout;
        end
      end

      // Starvation counter: counts CPU grants taken while the loader waits,
      // saturating so the forced-priority condition stays asserted.
      if (state_reg == IDLE) begin
        if (grant_ldr || !ldr_req) begin
          wait_cnt_reg <= '0;
        end else if (grant_cpu && !ldr_starved) begin
          wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
        end
      end
    end
  end

  // mem_wr and the acks decode straight from state so an asynchronous reset
  // removes them immediately.
  assign mem_wr   = (state_reg == ACCESS) && we_reg;
  assign cpu_ack  = (state_reg == DONE) && !owner_reg;
  assign ldr_ack  = (state_reg == DONE) &&  owner_reg;
  assign mem_addr = addr_reg;
  assign mem_din  = wdata_reg;
  assign rdata    = rdata_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset_l;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_ack;
  logic        ldr_req, ldr_we;
  logic [31:0] ldr_addr, ldr_wdata;
  logic        ldr_ack;
  logic [31:0] rdata, mem_addr, mem_din, mem_dout;
  logic        mem_wr, busy;

  int n_checks = 0;
  int n_fail   = 0;

  int          wr_cycles;
  int          busy_cycles;
  logic [31:0] last_din;
  bit          ack_q[$];   // 0 = CPU ack, 1 = loader ack

  logic [31:0] tb_mem [0:255];

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .MAX_WAIT(8)
  ) dut (
    .clock    (clock),
    .reset_l  (reset_l),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ack  (cpu_ack),
    .ldr_req  (ldr_req),
    .ldr_we   (ldr_we),
    .ldr_addr (ldr_addr),
    .ldr_wdata(ldr_wdata),
    .ldr_ack  (ldr_ack),
    .rdata    (rdata),
    .mem_addr (mem_addr),
    .mem_wr   (mem_wr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .busy     (busy)
  );

  // Memory model with one-cycle registered read: data for the address
  // presented in the first access cycle is valid in the second.
  always @(posedge clock) begin
    if (mem_wr === 1'b1) tb_mem[mem_addr[7:0]] <= mem_din;
    mem_dout <= tb_mem[mem_addr[7:0]];
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle of observation on the falling edge; optionally drop the acked
  // requester's req in its ack cycle.
  task automatic step(input bit drop);
    @(negedge clock);
    if (mem_wr === 1'b1) begin
      wr_cycles++;
      last_din = mem_din;
    end
    if (busy === 1'b1) busy_cycles++;
    if (cpu_ack === 1'b1) begin
      ack_q.push_back(1'b0);
      $display("txn: cpu ack, rdata=%08h", rdata);
      if (drop) cpu_req = 1'b0;
    end
    if (ldr_ack === 1'b1) begin
      ack_q.push_back(1'b1);
      $display("txn: ldr ack, rdata=%08h", rdata);
      if (drop) ldr_req = 1'b0;
    end
  endtask

  task automatic clear_counts();
    wr_cycles   = 0;
    busy_cycles = 0;
    last_din    = '0;
    ack_q.delete();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_rdata"},    rdata,    32'h0);
    check_val({pfx, "_mem_addr"}, mem_addr, 32'h0);
    check_val({pfx, "_mem_din"},  mem_din,  32'h0);
    check_val({pfx, "_mem_wr"},   mem_wr,   1'b0);
    check_val({pfx, "_cpu_ack"},  cpu_ack,  1'b0);
    check_val({pfx, "_ldr_ack"},  ldr_ack,  1'b0);
    check_val({pfx, "_busy"},     busy,     1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] <= 32'h0;
    tb_mem[8'h40] <= 32'hDEADBEEF;

    reset_l = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
    clear_counts();
    repeat (3) @(negedge clock);
    check_reset_outputs("por");
    reset_l = 1'b1;

    // CPU read of 0x40, request sampled at edge T
    @(negedge clock);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    @(negedge clock);                       // after T
    check_val("rd_busy_t1",  busy,     1'b1);
    check_val("rd_addr_t1",  mem_addr, 32'h40);
    check_val("rd_ack_t1",   cpu_ack,  1'b0);
    @(negedge clock);                       // after T+1
    check_val("rd_addr_t2",  mem_addr, 32'h40);
    check_val("rd_wr_t2",    mem_wr,   1'b0);
    check_val("rd_ack_t2",   cpu_ack,  1'b0);
    @(negedge clock);                       // cycle T+3
    check_val("rd_cpu_ack",  cpu_ack,  1'b1);
    check_val("rd_ldr_ack",  ldr_ack,  1'b0);
    check_val("rd_rdata",    rdata,    32'hDEADBEEF);
    $display("txn: cpu read 0x40 -> %08h", rdata);
    cpu_req = 0;
    @(negedge clock);
    check_val("rd_ack_gone", cpu_ack,  1'b0);
    check_val("rd_idle",     busy,     1'b0);

    // Loader write 0x12345678 to 0x10
    clear_counts();
    ldr_req = 1; ldr_we = 1; ldr_addr = 32'h10; ldr_wdata = 32'h12345678;
    for (int i = 0; i < 8; i++) step(1'b1);
    check_val("wr_cycles",   wr_cycles,        2);
    check_val("wr_din",      last_din,         32'h12345678);
    check_val("wr_acks",     ack_q.size(),     1);
    if (ack_q.size() > 0) check_val("wr_ack_owner", ack_q[0], 1'b1);
    check_val("wr_rdata",    rdata,            32'hDEADBEEF);
    check_val("wr_mem",      tb_mem[8'h10],    32'h12345678);

    // Mid-simulation reset, then 10 idle cycles
    @(negedge clock);
    reset_l = 1'b0;
    #1;
    check_reset_outputs("mid");
    @(negedge clock);
    reset_l = 1'b1;
    clear_counts();
    for (int i = 0; i < 10; i++) step(1'b1);
    check_val("idle_wr",     wr_cycles,   0);
    check_val("idle_busy",   busy_cycles, 0);

    // Simultaneous requests: CPU read 0x40 then loader read 0x10
    clear_counts();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    ldr_req = 1; ldr_we = 0; ldr_addr = 32'h10;
    for (int i = 0; i < 12; i++) step(1'b1);
    check_val("sim_acks",    ack_q.size(), 2);
    if (ack_q.size() == 2) begin
      check_val("sim_first",  ack_q[0], 1'b0);
      check_val("sim_second", ack_q[1], 1'b1);
    end
    check_val("sim_rdata",   rdata,        32'h12345678);

    // Starvation: both requests held continuously
    clear_counts();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    ldr_req = 1; ldr_we = 0; ldr_addr = 32'h10;
    for (int i = 0; i < 80 && ack_q.size() < 10; i++) step(1'b0);
    cpu_req = 0; ldr_req = 0;
    check_val("starve_count", ack_q.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < ack_q.size())
        check_val($sformatf("starve_ack%0d", i), ack_q[i], (i == 8) ? 1'b1 : 1'b0);
    end
    repeat (6) step(1'b1);

    // Abort: reset during a CPU write
    clear_counts();
    @(negedge clock);
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'hAAAA5555;
    @(negedge clock);
    check_val("abt_wr_before", mem_wr, 1'b1);
    #2 reset_l = 1'b0;
    #1;
    check_val("abt_wr_after",  mem_wr,  1'b0);
    check_val("abt_busy",      busy,    1'b0);
    check_val("abt_ack",       cpu_ack, 1'b0);
    cpu_req = 0;
    @(negedge clock);
    reset_l = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1);
    check_val("abt_no_ack",    ack_q.size(),  0);
    check_val("abt_mem_clean", tb_mem[8'h20], 32'h0);
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'hAAAA5555;
    for (int i = 0; i < 8; i++) step(1'b1);
    check_val("abt_retry_acks", ack_q.size(),  1);
    check_val("abt_retry_wr",   wr_cycles,     2);
    check_val("abt_retry_mem",  tb_mem[8'h20], 32'hAAAA5555);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
